// File: rtl/regfile_mp_sb_if.sv
// Issue/write-back bus of the multi-port register file with busy scoreboard.
// The master drives the strobes and indices; the register file is the slave.
interface regfile_mp_sb_if #(
    parameter int N   = 8,
    parameter int R   = 32,
    parameter int NRD = 2
);
    localparam int RR = $clog2(R);

    logic              wr_en;
    logic [RR-1:0]     wr_id;
    logic [N-1:0]      wr_data;
    logic [NRD-1:0]    rd_en;
    logic [NRD*RR-1:0] rd_id;
    logic [NRD*N-1:0]  rd_data;
    logic [NRD-1:0]    rd_valid;
    logic [NRD-1:0]    rd_busy;
    logic              rsv_en;
    logic [RR-1:0]     rsv_id;
    logic [R-1:0]      busy;

    modport master (
        output wr_en, wr_id, wr_data, rd_en, rd_id, rsv_en, rsv_id,
        input  rd_data, rd_valid, rd_busy, busy
    );

    modport slave (
        input  wr_en, wr_id, wr_data, rd_en, rd_id, rsv_en, rsv_id,
        output rd_data, rd_valid, rd_busy, busy
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Register file: 1 write port, NRD registered read ports with write-first bypass,
// per-register busy scoreboard and optional hardwired-zero R0.
module regfile_mp_sb #(
    parameter int N       = 8,
    parameter int R       = 32,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    localparam int RR     = $clog2(R)
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave bus
);

    logic [N-1:0]      r_regs [R];
    logic [R-1:0]      r_busy;
    logic [NRD*N-1:0]  r_rd_data;
    logic [NRD-1:0]    r_rd_valid;
    logic [NRD-1:0]    r_rd_busy;

    logic              w_wr_ok;
    logic              w_rsv_ok;
    logic [RR-1:0]     w_rd_idx [NRD];
    logic [N-1:0]      w_rd_val [NRD];
    logic [NRD-1:0]    w_rd_bsy;

    // An index is usable when it is in range and not the hardwired-zero R0.
    function automatic logic id_ok(input logic [RR-1:0] id);
        id_ok = (32'(id) < 32'(R)) && !((ZERO_R0 != 0) && (id == RR'(0)));
    endfunction

    // Qualify write and reservation strobes against the index rules.
    always_comb begin
        w_wr_ok  = bus.wr_en  && id_ok(bus.wr_id);
        w_rsv_ok = bus.rsv_en && id_ok(bus.rsv_id);
    end

    // Per-port read value and busy flag, with same-edge write bypass.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            w_rd_idx[p] = bus.rd_id[p*RR +: RR];
            w_rd_val[p] = '0;
            w_rd_bsy[p] = 1'b0;
            if (!id_ok(w_rd_idx[p])) begin
                w_rd_val[p] = '0;
                w_rd_bsy[p] = 1'b0;
            end else if (bus.wr_en && (bus.wr_id == w_rd_idx[p])) begin
                w_rd_val[p] = bus.wr_data;
                w_rd_bsy[p] = 1'b0;
            end else begin
                w_rd_val[p] = r_regs[w_rd_idx[p]];
                w_rd_bsy[p] = r_busy[w_rd_idx[p]];
            end
        end
    end

    // Register array, scoreboard and read-port output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < R; i++) begin
                r_regs[i] <= '0;
            end
            r_busy     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= '0;
            r_rd_busy  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[bus.wr_id] <= bus.wr_data;
            end
            // A reservation in the same cycle as the write-back wins: new producer.
            for (int i = 0; i < R; i++) begin
                if (w_rsv_ok && (bus.rsv_id == RR'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_ok && (bus.wr_id == RR'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
            for (int p = 0; p < NRD; p++) begin
                if (bus.rd_en[p]) begin
                    r_rd_data[p*N +: N] <= w_rd_val[p];
                    r_rd_busy[p]        <= w_rd_bsy[p];
                    r_rd_valid[p]       <= 1'b1;
                end else begin
                    r_rd_valid[p]       <= 1'b0;
                end
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_busy  = r_rd_busy;
    assign bus.busy     = r_busy;

endmodule
